// File: rtl/spram_arbiter_pkg.sv
// Shared defaults, request record and round-robin pointer helper for the
// single-port RAM arbiter.
package spram_arbiter_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_BURST_MAX  = 4;

  typedef struct packed {
    logic                      we;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } req_t;

  // Pointer to the requester after id, wrapping at num (num need not be 2^n).
  function automatic int next_ptr(input int id, input int num);
    return (id == num - 1) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/spram_arbiter_if.sv
// Requester-side command and response bundle of the SPRAM arbiter; clients
// use the master view, the arbiter the slave view.
interface spram_arbiter_if
  import spram_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/spram_arbiter_rr_select.sv
// Combinational rotate-priority picker: first set request at or above start,
// wrapping from NUM_REQ-1 back to 0.
module rr_select
  import spram_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] start,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                any
);

  int                idx;
  logic [ID_WIDTH-1:0] pos;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    pos      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      pos = ID_WIDTH'(idx);
      if (!any && req[pos]) begin
        any       = 1'b1;
        grant[pos] = 1'b1;
        grant_id  = pos;
      end
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one synchronous-read single-port RAM between NUM_REQ requesters using
// round-robin arbitration with a bounded burst for the current owner.
module spram_arbiter
  import spram_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BURST_MAX  = DEF_BURST_MAX,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  spram_arbiter_if.slave        bus,
  output logic                  mem_wea,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam int CNT_WIDTH = $clog2(BURST_MAX + 1);

  logic                 owner_valid;
  logic [ID_WIDTH-1:0]  owner_id;
  logic [ID_WIDTH-1:0]  rr_ptr;
  logic [CNT_WIDTH-1:0] burst_cnt;
  logic [NUM_REQ-1:0]   rsp_pend;

  logic [NUM_REQ-1:0]   rr_grant;
  logic [ID_WIDTH-1:0]  rr_id;
  logic                 rr_any;
  logic                 owner_keep;
  logic                 grant_any;
  logic [ID_WIDTH-1:0]  grant_id;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
    assign addr_arr[i]  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_select #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_select (
    .req      (bus.req_valid),
    .start    (rr_ptr),
    .grant    (rr_grant),
    .grant_id (rr_id),
    .any      (rr_any)
  );

  // The owner keeps the port while it still asks and has burst budget left;
  // otherwise the rotating scan decides, which may re-pick an exhausted owner.
  always_comb begin
    owner_keep    = owner_valid && bus.req_valid[owner_id] &&
                    (burst_cnt < CNT_WIDTH'(BURST_MAX));
    grant_any     = !rst && (owner_keep || rr_any);
    grant_id      = owner_keep ? owner_id : rr_id;
    bus.req_ready = '0;
    if (!rst) bus.req_ready = owner_keep ? (NUM_REQ'(1) << owner_id) : rr_grant;
  end

  always_comb begin
    mem_wea  = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (grant_any) begin
      mem_wea  = bus.req_we[grant_id];
      mem_addr = addr_arr[grant_id];
      mem_din  = wdata_arr[grant_id];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_valid <= 1'b0;
      owner_id    <= '0;
      burst_cnt   <= '0;
      rr_ptr      <= '0;
      rsp_pend    <= '0;
    end else begin
      rsp_pend <= bus.req_ready & ~bus.req_we;
      if (grant_any) begin
        owner_valid <= 1'b1;
        owner_id    <= grant_id;
        burst_cnt   <= owner_keep ? burst_cnt + 1'b1 : CNT_WIDTH'(1);
        rr_ptr      <= ID_WIDTH'(next_ptr(int'(grant_id), NUM_REQ));
      end else begin
        owner_valid <= 1'b0;
        burst_cnt   <= '0;
      end
    end
  end

  // Read data comes straight from the RAM; only the strobe qualifies it.
  assign bus.rsp_valid = rst ? '0 : rsp_pend;
  assign bus.rsp_data  = mem_dout;

endmodule
